// File: rtl/usb_boot_sequencer.sv
// Boot hand-off sequencer: watches SOF host presence and bridge boot requests, then drains SPI,
// detaches from USB and asserts a held warm-boot with the selected image.
module usb_boot_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 48000000,
  parameter int unsigned DRAIN_CYCLES   = 48,
  parameter int unsigned DETACH_CYCLES  = 480000,
  parameter logic [1:0]  DEFAULT_IMAGE  = 2'd1,
  parameter int unsigned TIMER_W        = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sof_valid,
  input  logic       boot_req,
  input  logic [1:0] boot_req_image,
  input  logic       spi_cs_b,
  output logic       host_seen,
  output logic       usb_detach,
  output logic       boot,
  output logic [1:0] boot_image,
  output logic [2:0] seq_state
);

  localparam logic [2:0] StWait   = 3'd0;
  localparam logic [2:0] StDrain  = 3'd1;
  localparam logic [2:0] StDetach = 3'd2;
  localparam logic [2:0] StBoot   = 3'd3;

  localparam logic [TIMER_W-1:0] TimeoutLast = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DrainLast   = TIMER_W'(DRAIN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DetachLast  = TIMER_W'(DETACH_CYCLES - 1);

  logic [2:0]         state_q;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_inc;

  // Saturate rather than wrap so an undersized timer can never re-trigger a boot.
  assign timer_inc = (&timer_q) ? timer_q : timer_q + TIMER_W'(1);
  assign seq_state = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StWait;
      timer_q    <= '0;
      host_seen  <= 1'b0;
      usb_detach <= 1'b0;
      boot       <= 1'b0;
      boot_image <= DEFAULT_IMAGE;
    end else begin
      case (state_q)
        StWait: begin
          if (sof_valid) host_seen <= 1'b1;
          // A boot request outranks both SOF keep-alive and the timeout.
          if (boot_req) begin
            boot_image <= boot_req_image;
            timer_q    <= '0;
            state_q    <= StDrain;
          end else if (sof_valid) begin
            timer_q <= '0;
          end else if (timer_q == TimeoutLast) begin
            boot_image <= DEFAULT_IMAGE;
            timer_q    <= '0;
            state_q    <= StDrain;
          end else begin
            timer_q <= timer_inc;
          end
        end
        StDrain: begin
          if (!spi_cs_b) begin
            timer_q <= '0;
          end else if (timer_q == DrainLast) begin
            timer_q    <= '0;
            usb_detach <= 1'b1;
            state_q    <= StDetach;
          end else begin
            timer_q <= timer_inc;
          end
        end
        StDetach: begin
          usb_detach <= 1'b1;
          if (timer_q == DetachLast) begin
            boot    <= 1'b1;
            timer_q <= '0;
            state_q <= StBoot;
          end else begin
            timer_q <= timer_inc;
          end
        end
        StBoot: begin
          usb_detach <= 1'b1;
          boot       <= 1'b1;
        end
        default: begin
          state_q    <= StWait;
          timer_q    <= '0;
          usb_detach <= 1'b0;
          boot       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_boot_sequencer.sv
// Directed bench for usb_boot_sequencer with shortened timing parameters.
module tb_usb_boot_sequencer;

  localparam int unsigned Timeout = 100;
  localparam int unsigned Drain   = 4;
  localparam int unsigned Detach  = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       sof_valid = 1'b0;
  logic       boot_req = 1'b0;
  logic [1:0] boot_req_image = 2'd0;
  logic       spi_cs_b = 1'b1;
  logic       host_seen;
  logic       usb_detach;
  logic       boot;
  logic [1:0] boot_image;
  logic [2:0] seq_state;

  int vec_cnt = 0;
  int err_cnt = 0;

  usb_boot_sequencer #(
    .TIMEOUT_CYCLES(Timeout),
    .DRAIN_CYCLES  (Drain),
    .DETACH_CYCLES (Detach),
    .DEFAULT_IMAGE (2'd1),
    .TIMER_W       (32)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .sof_valid     (sof_valid),
    .boot_req      (boot_req),
    .boot_req_image(boot_req_image),
    .spi_cs_b      (spi_cs_b),
    .host_seen     (host_seen),
    .usb_detach    (usb_detach),
    .boot          (boot),
    .boot_image    (boot_image),
    .seq_state     (seq_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted and released 1 time unit after a clock edge.
  task automatic do_reset();
    reset_n = 1'b0;
    sof_valid = 1'b0;
    boot_req = 1'b0;
    spi_cs_b = 1'b1;
    step();
    reset_n = 1'b1;
  endtask

  task automatic edges_until_detach(input int bound, output int cnt);
    cnt = 0;
    while (!usb_detach && cnt < bound) begin
      step();
      cnt++;
    end
  endtask

  task automatic edges_until_boot(input int bound, output int cnt);
    cnt = 0;
    while (!boot && cnt < bound) begin
      step();
      cnt++;
    end
  endtask

  task automatic pulse_req(input logic [1:0] img);
    boot_req = 1'b1;
    boot_req_image = img;
    step();
    boot_req = 1'b0;
  endtask

  int  n;
  bit  bad;
  bit  seen_early;

  initial begin
    // Reset values
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_state", 32'(seq_state), 32'd0);
    check_eq("rst_host_seen", 32'(host_seen), 32'd0);
    check_eq("rst_detach", 32'(usb_detach), 32'd0);
    check_eq("rst_boot", 32'(boot), 32'd0);
    check_eq("rst_image", 32'(boot_image), 32'd1);
    step();
    reset_n = 1'b1;

    // Illegal state recovers to WAIT
    step();
    step();
    force dut.state_q = 3'd6;
    #1;
    check_eq("illegal_forced", 32'(seq_state), 32'd6);
    release dut.state_q;
    step();
    check_eq("illegal_recover", 32'(seq_state), 32'd0);
    check_eq("illegal_boot", 32'(boot), 32'd0);
    check_eq("illegal_detach", 32'(usb_detach), 32'd0);

    // SOF keep-alive every 50 cycles, first pulse at cycle 10
    do_reset();
    bad = 1'b0;
    seen_early = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      sof_valid = (i % 50 == 10);
      step();
      if (i < 10 && host_seen) seen_early = 1'b1;
      if (i >= 10 && !host_seen) bad = 1'b1;
      if (usb_detach || boot) bad = 1'b1;
    end
    sof_valid = 1'b0;
    check_eq("keepalive_early_host", 32'(seen_early), 32'd0);
    check_eq("keepalive_hold", 32'(bad), 32'd0);
    check_eq("keepalive_state", 32'(seq_state), 32'd0);

    // Timeout boot: 100 WAIT edges (last one leaves) plus 4 DRAIN edges
    do_reset();
    edges_until_detach(500, n);
    check_eq("timeout_detach_lat", 32'(n), Timeout + Drain);
    check_eq("timeout_state_detach", 32'(seq_state), 32'd2);
    check_eq("timeout_host_seen", 32'(host_seen), 32'd0);
    check_eq("timeout_boot_early", 32'(boot), 32'd0);
    edges_until_boot(200, n);
    check_eq("timeout_boot_lat", 32'(n), Detach);
    check_eq("timeout_image", 32'(boot_image), 32'd1);
    check_eq("timeout_state_boot", 32'(seq_state), 32'd3);

    // Requested boot, image 3, flash busy for 20 cycles
    do_reset();
    for (int i = 0; i < 20; i++) step();
    spi_cs_b = 1'b0;
    pulse_req(2'd3);
    check_eq("busy_state_drain", 32'(seq_state), 32'd1);
    for (int i = 0; i < 19; i++) step();
    check_eq("busy_no_detach", 32'(usb_detach), 32'd0);
    spi_cs_b = 1'b1;
    edges_until_detach(100, n);
    check_eq("busy_detach_lat", 32'(n), Drain);
    check_eq("busy_image", 32'(boot_image), 32'd3);
    edges_until_boot(200, n);
    check_eq("busy_boot_lat", 32'(n), Detach);
    bad = 1'b0;
    for (int i = 0; i < 500; i++) begin
      sof_valid = (i % 37 == 0);
      boot_req = (i == 100);
      boot_req_image = 2'd0;
      spi_cs_b = (i % 3 != 0);
      step();
      if (!boot || !usb_detach || boot_image != 2'd3 || seq_state != 3'd3) bad = 1'b1;
    end
    sof_valid = 1'b0;
    boot_req = 1'b0;
    spi_cs_b = 1'b1;
    check_eq("busy_boot_held", 32'(bad), 32'd0);

    // Collision: boot_req on the timeout edge wins
    do_reset();
    for (int i = 0; i < int'(Timeout) - 1; i++) step();
    check_eq("coll_still_wait", 32'(seq_state), 32'd0);
    pulse_req(2'd2);
    check_eq("coll_state", 32'(seq_state), 32'd1);
    check_eq("coll_image", 32'(boot_image), 32'd2);
    edges_until_detach(100, n);
    check_eq("coll_detach_lat", 32'(n), Drain);
    step();
    step();
    pulse_req(2'd0);
    check_eq("coll_ignore_state", 32'(seq_state), 32'd2);
    check_eq("coll_ignore_image", 32'(boot_image), 32'd2);
    edges_until_boot(200, n);
    check_eq("coll_boot_lat", 32'(n), Detach - 3);
    check_eq("coll_final_image", 32'(boot_image), 32'd2);

    // Async reset mid-cycle during DETACH
    do_reset();
    pulse_req(2'd3);
    edges_until_detach(100, n);
    step();
    step();
    check_eq("arst_pre_state", 32'(seq_state), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_state", 32'(seq_state), 32'd0);
    check_eq("arst_detach", 32'(usb_detach), 32'd0);
    check_eq("arst_boot", 32'(boot), 32'd0);
    check_eq("arst_image", 32'(boot_image), 32'd1);
    step();
    reset_n = 1'b1;
    boot_req = 1'b1;
    boot_req_image = 2'd2;
    step();
    boot_req = 1'b0;
    edges_until_detach(100, n);
    check_eq("arst_restart_lat", 32'(n + 1), Drain + 1);
    check_eq("arst_restart_image", 32'(boot_image), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
